// File: rtl/corePckg.sv
// Shared core package: register-file geometry, default pipeline latencies and
// the issue-controller state type.
//
// Contents:
//   cRegSelBitW   width of a register address
//   cNumRegs      number of architectural registers
//   cAluLat       default cycles from issue until an ALU-class result is consumable
//   cLoadLat      default cycles from issue until a load result is consumable
//   cFlushCycles  default number of cycles issue is blocked after a flush
//   tIssueStateEnum  issue-controller FSM states
//   cntWidth()    width of a countdown that must hold values 0..lat
package corePckg;

  localparam int unsigned cRegSelBitW  = 5;
  localparam int unsigned cNumRegs     = 32;
  localparam int unsigned cAluLat      = 1;
  localparam int unsigned cLoadLat     = 3;
  localparam int unsigned cFlushCycles = 2;

  typedef enum logic [1:0] {
    eIsRun,
    eIsFence,
    eIsFlush
  } tIssueStateEnum;

  // Never returns 0 so a degenerate latency still yields a legal vector.
  function automatic int unsigned cntWidth(input int unsigned lat);
    int unsigned w;
    w = $clog2(lat + 1);
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/reg_countdown.sv
// Single-register result countdown for the issue scoreboard.
//
// The counter holds the number of cycles until the in-flight result for this
// register has fully retired. A new load takes priority over the per-cycle
// decrement.
//
// Ports:
//   iClk      clock, rising edge
//   iRst      synchronous active-high reset, clears the counter
//   iLoad     load iLoadVal this cycle (overrides the decrement)
//   iLoadVal  new countdown value
//   oBusy     counter is nonzero (result still in flight)
//   oPending  counter is above 1: the result cannot even be bypassed this cycle
module reg_countdown #(
  parameter int unsigned pCntW = 2
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iLoad,
  input  logic [pCntW-1:0] iLoadVal,
  output logic             oBusy,
  output logic             oPending
);

  logic [pCntW-1:0] cntQ;
  logic [pCntW-1:0] cntD;

  always_comb begin
    cntD = cntQ;
    if (iLoad) begin
      cntD = iLoadVal;
    end else if (cntQ != '0) begin
      cntD = cntQ - pCntW'(1);
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      cntQ <= '0;
    end else begin
      cntQ <= cntD;
    end
  end

  assign oBusy    = (cntQ != '0);
  assign oPending = (cntQ > pCntW'(1));

endmodule

// File: rtl/issue_scoreboard.sv
// Register-hazard scoreboard and issue controller sitting between decode and
// execute. One countdown per architectural register tracks results in flight;
// the decoded candidate issues only when its sources are ready. The block also
// blocks issue for a fixed window after a flush and drains all outstanding
// writes before letting a fence through.
//
// A countdown of 1 means the result is produced this cycle and reaches the
// consumer through the bypass network, so only counters above 1 stall a reader.
// This gives consumer issue cycle = producer issue cycle + latency. The fence,
// by contrast, waits until every counter is fully 0.
//
// Ports:
//   iClk, iRst                    clock, synchronous active-high reset
//   iValid                        decoded candidate present
//   iRs1Addr, iRs2Addr, iRdAddr   candidate register addresses
//   iUseRs1, iUseRs2              candidate reads rs1 / rs2
//   iWritesRd                     candidate writes rd
//   iIsLoad                       candidate is a load (long latency)
//   iIsFence                      candidate is a fence
//   iFlush                        one-cycle flush request from branch resolution
//   oIssue                        candidate accepted this cycle (combinational)
//   oStall                        candidate present but held (combinational)
//   oFlushActive                  controller is in the flush window (registered)
//   oBusyVec                      bit r set while register r has a result in flight
module issue_scoreboard
  import corePckg::*;
#(
  parameter int unsigned pAluLat      = cAluLat,
  parameter int unsigned pLoadLat     = cLoadLat,
  parameter int unsigned pFlushCycles = cFlushCycles
) (
  input  logic                   iClk,
  input  logic                   iRst,
  input  logic                   iValid,
  input  logic [cRegSelBitW-1:0] iRs1Addr,
  input  logic [cRegSelBitW-1:0] iRs2Addr,
  input  logic [cRegSelBitW-1:0] iRdAddr,
  input  logic                   iUseRs1,
  input  logic                   iUseRs2,
  input  logic                   iWritesRd,
  input  logic                   iIsLoad,
  input  logic                   iIsFence,
  input  logic                   iFlush,
  output logic                   oIssue,
  output logic                   oStall,
  output logic                   oFlushActive,
  output logic [cNumRegs-1:0]    oBusyVec
);

  localparam int unsigned cCntW   = cntWidth(pLoadLat);
  localparam int unsigned cFlushW = cntWidth(pFlushCycles - 1);

  tIssueStateEnum     stateQ;
  tIssueStateEnum     stateD;
  logic [cFlushW-1:0] flushCntQ;
  logic [cFlushW-1:0] flushCntD;

  logic [cNumRegs-1:0] busyVec;
  logic [cNumRegs-1:0] pendingVec;
  logic [cNumRegs-1:0] loadVec;
  logic [cCntW-1:0]    loadVal;
  logic                hazard;
  logic                anyBusy;
  logic                issue;
  logic                rdLoad;

  // Per-register countdowns; x0 is never tracked.
  assign busyVec[0]    = 1'b0;
  assign pendingVec[0] = 1'b0;

  assign rdLoad  = issue & iWritesRd & (iRdAddr != '0);
  assign loadVal = iIsLoad ? cCntW'(pLoadLat) : cCntW'(pAluLat);

  always_comb begin
    loadVec = '0;
    if (rdLoad) begin
      loadVec[iRdAddr] = 1'b1;
    end
  end

  for (genvar r = 1; r < cNumRegs; r++) begin : gCnt
    reg_countdown #(
      .pCntW(cCntW)
    ) uCnt (
      .iClk    (iClk),
      .iRst    (iRst),
      .iLoad   (loadVec[r]),
      .iLoadVal(loadVal),
      .oBusy   (busyVec[r]),
      .oPending(pendingVec[r])
    );
  end

  assign hazard  = (iUseRs1 & pendingVec[iRs1Addr]) | (iUseRs2 & pendingVec[iRs2Addr]);
  assign anyBusy = |busyVec;

  // Next state and issue decision; iFlush overrides every state.
  always_comb begin
    stateD    = stateQ;
    flushCntD = flushCntQ;
    issue     = 1'b0;

    unique case (stateQ)
      eIsRun: begin
        issue = iValid & ~hazard & ~(iIsFence & anyBusy);
        if (iValid & iIsFence & anyBusy) begin
          stateD = eIsFence;
        end
      end
      eIsFence: begin
        if (!iValid) begin
          stateD = eIsRun;
        end else if (!anyBusy) begin
          issue  = 1'b1;
          stateD = eIsRun;
        end
      end
      eIsFlush: begin
        if (flushCntQ == '0) begin
          stateD = eIsRun;
        end else begin
          flushCntD = flushCntQ - cFlushW'(1);
        end
      end
      default: begin
        stateD = eIsRun;
      end
    endcase

    if (iFlush) begin
      issue     = 1'b0;
      stateD    = eIsFlush;
      flushCntD = cFlushW'(pFlushCycles - 1);
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      stateQ    <= eIsRun;
      flushCntQ <= '0;
    end else begin
      stateQ    <= stateD;
      flushCntQ <= flushCntD;
    end
  end

  assign oIssue       = issue;
  assign oStall       = iValid & ~issue;
  assign oFlushActive = (stateQ == eIsFlush);
  assign oBusyVec     = busyVec;

endmodule
